// File: rtl/ring_pkg.sv
// ring_pkg: packet layout helpers, serialiser states and shortest-path routing for the ring node.
package ring_pkg;
  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} ser_state_e;
  typedef enum logic [1:0] {TO_RIGHT, TO_LEFT, TO_LOCAL, TO_DROP} route_e;
  function automatic int dest_lsb(int addr_w, int payload_w);
    return addr_w + payload_w;
  endfunction
  function automatic int src_lsb(int payload_w);
    return payload_w;
  endfunction
  // Hop distance going right; ties (exactly half way round) go right.
  function automatic logic go_right(int dest, int node, int n);
    return ((dest - node + n) % n) <= n / 2;
  endfunction
endpackage

// File: rtl/ring_link_port.sv
// ring_link_port: bit-serial deserialiser with holding register plus FIFO-fed serialiser.
module ring_link_port
  import ring_pkg::*;
#(
  parameter int PKT_W = 14
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_data_i,
  input  logic             in_cs_i,
  input  logic             take_i,
  output logic [PKT_W-1:0] hold_o,
  output logic             hold_vld_o,
  output logic             abort_o,
  output logic             ovf_o,
  input  logic [PKT_W-1:0] tx_pkt_i,
  input  logic             tx_rdy_i,
  output logic             pop_o,
  output logic             out_data_o,
  output logic             out_cs_o
);
  localparam int CW = $clog2(PKT_W + 1);
  logic [CW-1:0]    rx_cnt_q, tx_cnt_q;
  logic [PKT_W-2:0] rx_sr_q;
  logic [PKT_W-1:0] hold_q, tx_sr_q;
  logic             hold_vld_q, last;
  ser_state_e       st_q, st_d;
  assign last       = in_cs_i && rx_cnt_q == CW'(PKT_W - 1);
  assign abort_o    = !in_cs_i && rx_cnt_q != '0 && rx_cnt_q != CW'(PKT_W);
  assign ovf_o      = last && hold_vld_q && !take_i;
  assign hold_o     = hold_q;
  assign hold_vld_o = hold_vld_q;
  // A count of PKT_W means the frame is complete and further bits are ignored until CS drops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_cnt_q   <= '0;
      rx_sr_q    <= '0;
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
    end else begin
      if (!in_cs_i) rx_cnt_q <= '0;
      else if (rx_cnt_q != CW'(PKT_W)) begin
        rx_sr_q  <= {rx_sr_q[PKT_W-3:0], in_data_i};
        rx_cnt_q <= rx_cnt_q + 1'b1;
      end
      if (take_i) hold_vld_q <= 1'b0;
      if (last && !ovf_o) begin
        hold_q     <= {rx_sr_q, in_data_i};
        hold_vld_q <= 1'b1;
      end
    end
  end
  // Reloading straight from GAP keeps back-to-back frames exactly one idle cycle apart.
  always_comb begin
    pop_o = st_q != S_SEND && tx_rdy_i;
    st_d  = pop_o ? S_SEND :
            (st_q == S_SEND && tx_cnt_q == CW'(PKT_W - 1)) ? S_GAP :
            (st_q == S_GAP) ? S_IDLE : st_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q     <= S_IDLE;
      tx_sr_q  <= '0;
      tx_cnt_q <= '0;
    end else begin
      st_q <= st_d;
      if (pop_o) begin
        tx_sr_q  <= tx_pkt_i;
        tx_cnt_q <= '0;
      end else if (st_q == S_SEND) begin
        tx_sr_q  <= tx_sr_q << 1;
        tx_cnt_q <= tx_cnt_q + 1'b1;
      end
    end
  end
  assign out_cs_o   = st_q == S_SEND;
  assign out_data_o = out_cs_o && tx_sr_q[PKT_W-1];
endmodule

// File: rtl/ring_router_node.sv
// ring_router_node: bidirectional ring node routing bit-serial packets by shortest path.
module ring_router_node
  import ring_pkg::*;
#(
  parameter int NODE_ADDR  = 0,
  parameter int NUM_NODES  = 5,
  parameter int ADDR_W     = 3,
  parameter int PAYLOAD_W  = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       shiftInRightData,
  input  logic       shiftInRightCS,
  input  logic       shiftInLeftData,
  input  logic       shiftInLeftCS,
  input  logic       shiftInData,
  input  logic       shiftInCS,
  output logic       shiftOutRightData,
  output logic       shiftOutRightCS,
  output logic       shiftOutLeftData,
  output logic       shiftOutLeftCS,
  output logic       shiftOutData,
  output logic       shiftOutCS,
  output logic [7:0] dropCount
);
  localparam int PKT_W = 2 * ADDR_W + PAYLOAD_W;
  localparam int DL    = dest_lsb(ADDR_W, PAYLOAD_W);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int FCW   = AW + 1;
  // Index 0 = rightward link, 1 = leftward link, 2 = local port, for inputs, FIFOs and outputs alike.
  logic [2:0]       in_d, in_cs, take, abort, ovf, vld, pop, push, full, rdy, out_d, out_cs, disc;
  logic [PKT_W-1:0] hold[3], head[3], wdata[3];
  route_e           tgt[3];
  logic [3:0]       ev;
  logic [8:0]       tot;
  logic [7:0]       drop_q, drop_d;
  assign in_d  = {shiftInData, shiftInLeftData, shiftInRightData};
  assign in_cs = {shiftInCS, shiftInLeftCS, shiftInRightCS};
  assign {shiftOutData, shiftOutLeftData, shiftOutRightData} = out_d;
  assign {shiftOutCS, shiftOutLeftCS, shiftOutRightCS}       = out_cs;
  assign dropCount = drop_q;
  for (genvar p = 0; p < 3; p++) begin : g_port
    ring_link_port #(.PKT_W(PKT_W)) u_port (
      .clk       (clk),
      .reset     (reset),
      .in_data_i (in_d[p]),
      .in_cs_i   (in_cs[p]),
      .take_i    (take[p]),
      .hold_o    (hold[p]),
      .hold_vld_o(vld[p]),
      .abort_o   (abort[p]),
      .ovf_o     (ovf[p]),
      .tx_pkt_i  (head[p]),
      .tx_rdy_i  (rdy[p]),
      .pop_o     (pop[p]),
      .out_data_o(out_d[p]),
      .out_cs_o  (out_cs[p])
    );
  end
  // Transit traffic keeps its direction; only local injections choose the shortest way round.
  for (genvar h = 0; h < 3; h++) begin : g_route
    logic [ADDR_W-1:0] dest;
    assign dest    = hold[h][DL +: ADDR_W];
    assign tgt[h]  = (dest == ADDR_W'(NODE_ADDR)) ? TO_LOCAL :
                     (int'(dest) >= NUM_NODES) ? TO_DROP :
                     (h == 2) ? (go_right(int'(dest), NODE_ADDR, NUM_NODES) ? TO_RIGHT : TO_LEFT) :
                     (h == 0) ? TO_RIGHT : TO_LEFT;
    assign disc[h] = vld[h] && tgt[h] == TO_DROP;
  end
  // Lower index wins a contended FIFO: rightward transit, then leftward transit, then local.
  always_comb begin
    push = '0;
    take = '0;
    for (int f = 0; f < 3; f++) wdata[f] = '0;
    for (int h = 0; h < 3; h++)
      if (vld[h]) begin
        if (tgt[h] == TO_DROP) take[h] = 1'b1;
        else if (!push[tgt[h]] && (!full[tgt[h]] || pop[tgt[h]])) begin
          take[h]        = 1'b1;
          push[tgt[h]]   = 1'b1;
          wdata[tgt[h]]  = hold[h];
        end
      end
  end
  for (genvar f = 0; f < 3; f++) begin : g_fifo
    logic [PKT_W-1:0] mem_q[FIFO_DEPTH];
    logic [AW-1:0]    wp_q, rp_q;
    logic [FCW-1:0]   cnt_q;
    assign full[f] = cnt_q == FCW'(FIFO_DEPTH);
    assign rdy[f]  = cnt_q != '0;
    assign head[f] = mem_q[rp_q];
    always_ff @(posedge clk) if (push[f]) mem_q[wp_q] <= wdata[f];
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        wp_q  <= '0;
        rp_q  <= '0;
        cnt_q <= '0;
      end else begin
        if (push[f]) wp_q <= wp_q + 1'b1;
        if (pop[f]) rp_q <= rp_q + 1'b1;
        cnt_q <= cnt_q + FCW'(push[f]) - FCW'(pop[f]);
      end
    end
  end
  always_comb begin
    ev = '0;
    for (int i = 0; i < 3; i++) ev = ev + 4'(abort[i]) + 4'(ovf[i]) + 4'(disc[i]);
    tot    = {1'b0, drop_q} + 9'(ev);
    drop_d = tot > 9'd255 ? 8'd255 : tot[7:0];
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) drop_q <= '0;
    else drop_q <= drop_d;
  end
endmodule
